// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full/empty flags, error pulses, sync flush.
// Latency: dout registered, valid 1 cycle after an accepted read; with SYNC_FIFO_FWFT_EN the head word is shown while !empty.
// Backpressure: writes refused while full (unless a read frees a slot this edge), reads refused while empty; refusals pulse overflow/underflow.
module sync_fifo_flags #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] PTR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_acc;
    logic              wr_acc;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Acceptance uses the registered flags; a read on a full FIFO frees the slot the write lands in.
    always_comb begin
        rd_acc = rd_en && !empty && !clr;
        wr_acc = wr_en && (!full || rd_acc) && !clr;
    end

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        // Wrap bit makes the plain difference the occupancy, 0..DEPTH.
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            overflow     <= wr_en && !wr_acc && !clr;
            underflow    <= rd_en && !rd_acc && !clr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = empty ? '0 : mem[rd_addr];
`else
    // Same-edge write to the head slot (full + read + write) still returns the old head here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= '0;
        end else if (clr) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: hand-computed vector table, directed corner sequences, then random traffic
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int AF = 14;
    localparam int AE = 2;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    sync_fifo_flags #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .AFULL_TH (AF),
        .AEMPTY_TH(AE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Reference model: the FIFO contents as a queue plus the last-cycle observables.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_of;
    logic          m_uf;

    typedef struct {
        logic          c;
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        int            cnt;
        logic          emp;
        logic          ful;
        logic          ae;
        logic          of;
        logic          uf;
        logic [DW-1:0] dstd;
        logic [DW-1:0] dfw;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
        bit            rd_ok;
        bit            wr_ok;
        logic [DW-1:0] popped;
        if (c) begin
            q.delete();
            m_dout = '0;
            m_of   = 1'b0;
            m_uf   = 1'b0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DP) || rd_ok);
            m_of  = w && !wr_ok;
            m_uf  = r && !rd_ok;
            if (rd_ok) begin
                popped = q.pop_front();
                if (!FWFT) m_dout = popped;
            end
            if (wr_ok) q.push_back(d);
        end
        if (FWFT) m_dout = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DP));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow",     32'(overflow),     32'(m_of));
        chk("underflow",    32'(underflow),    32'(m_uf));
        chk("dout",         32'(dout),         32'(m_dout));
    endtask

    // One clock: drive away from the edge, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
        clr   = c;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        model_step(c, w, d, r);
        #1;
        check_model();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rstn = 1'b1;
    endtask

    initial begin
        int wbias;
        rstn  = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // {clr, wr, din, rd, count, empty, full, almost_empty, overflow, underflow, dout std, dout fwft}
        vt[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 16'h1111, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h1111};
        vt[2] = '{1'b0, 1'b1, 16'h2222, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111};
        vt[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vt[4] = '{1'b0, 1'b1, 16'h3333, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h3333};
        vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h3333};
        vt[6] = '{1'b1, 1'b1, 16'h4444, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vt[8] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5555};
        vt[9] = '{1'b1, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};

        phase = "reset";
        do_reset();

        phase = "table";
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].c, vt[i].w, vt[i].d, vt[i].r);
            chk($sformatf("v%0d_count", i), 32'(count),     32'(vt[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty),     32'(vt[i].emp));
            chk($sformatf("v%0d_full", i),  32'(full),      32'(vt[i].ful));
            chk($sformatf("v%0d_ae", i),    32'(almost_empty), 32'(vt[i].ae));
            chk($sformatf("v%0d_of", i),    32'(overflow),  32'(vt[i].of));
            chk($sformatf("v%0d_uf", i),    32'(underflow), 32'(vt[i].uf));
            chk($sformatf("v%0d_dout", i),  32'(dout),      32'(FWFT ? vt[i].dfw : vt[i].dstd));
        end

        phase = "fill";
        for (int i = 1; i <= DP; i++) begin
            cycle(1'b0, 1'b1, DW'(i), 1'b0);
            chk($sformatf("af_at_%0d", i), 32'(almost_full), 32'(i >= 14));
        end
        chk("fill_full", 32'(full), 32'd1);

        phase = "overflow";
        cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("of_pulse", 32'(overflow), 32'd1);
        chk("of_count", 32'(count), 32'd16);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("of_drop", 32'(overflow), 32'd0);

        phase = "full_rw";
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, DW'(16'h0100 + i), 1'b1);
        chk("rw_count", 32'(count), 32'd16);

        phase = "drain";
        for (int i = 0; i < DP; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);

        phase = "underflow";
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("uf_pulse", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b1, 16'h0077, 1'b1);
        chk("uf_wr_count", 32'(count), 32'd1);
        chk("uf_wr_pulse", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        phase = "clr";
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, DW'(16'h0A00 + i), 1'b0);
        chk("pre_clr_count", 32'(count), 32'd9);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_dout", 32'(dout), 32'd0);

        phase = "async_reset";
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DW'(16'h0C00 + i), i[0]);
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'h0CCC;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        check_model();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rstn  = 1'b1;

        phase = "random";
        wbias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) wbias = $urandom_range(20, 80);
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < wbias),
                  DW'($urandom),
                  ($urandom_range(0, 99) >= wbias));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
